// File: rtl/tdc_capture_ctrl.sv
// Ring-oscillator TDC controller: opens the window, waits for the async done flag,
// double-samples the async count until stable and hands it out on valid/ready.
module tdc_capture_ctrl #(
  parameter int BIT_COUNT      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int MAX_SAMPLES    = 4,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  output logic                 osc_enable,
  output logic                 osc_reset,
  input  logic [BIT_COUNT-1:0] osc_count,
  input  logic                 osc_has_value,
  output logic [BIT_COUNT-1:0] result_data,
  output logic                 result_timeout,
  output logic                 result_unstable,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  localparam int WIN_W   = $clog2(TIMEOUT_CYCLES);
  localparam int DLY_MAX = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int ATT_W   = $clog2(MAX_SAMPLES + 1);

  typedef enum logic [2:0] {
    IDLE, MEASURE, WAIT_FLAG, SETTLE, SAMPLE, OUTPUT, CLEAR
  } state_t;

  state_t               state, state_d;
  logic [WIN_W-1:0]     win_cnt;
  logic [DLY_W-1:0]     dly_cnt;
  logic [ATT_W-1:0]     att_cnt;
  logic                 phase;
  logic [BIT_COUNT-1:0] s0;
  logic [SYNC_STAGES-1:0] has_sync;

  logic win_last, settle_last, clear_last, att_last, samp_match;
  logic en_d, rst_d, vld_d;

  assign win_last    = (win_cnt == WIN_W'(TIMEOUT_CYCLES - 1));
  assign settle_last = (dly_cnt == DLY_W'(SETTLE_CYCLES - 1));
  assign clear_last  = (dly_cnt == DLY_W'(CLEAR_CYCLES - 1));
  assign att_last    = (att_cnt == ATT_W'(MAX_SAMPLES - 1));
  // Second sample of a pair is compared as it is taken, so it never needs its own flop.
  assign samp_match  = (s0 == osc_count);

  // Plain synchroniser without reset so releasing reset cannot fake a flag edge.
  always_ff @(posedge clk)
    has_sync <= {has_sync[SYNC_STAGES-2:0], osc_has_value};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= CLEAR;
      win_cnt         <= '0;
      dly_cnt         <= '0;
      att_cnt         <= '0;
      phase           <= 1'b0;
      s0              <= '0;
      osc_enable      <= 1'b0;
      osc_reset       <= 1'b1;
      result_valid    <= 1'b0;
      result_data     <= '0;
      result_timeout  <= 1'b0;
      result_unstable <= 1'b0;
    end else begin
      state        <= state_d;
      osc_enable   <= en_d;
      osc_reset    <= rst_d;
      result_valid <= vld_d;
      case (state)
        IDLE: if (start) begin
          win_cnt         <= '0;
          result_timeout  <= 1'b0;
          result_unstable <= 1'b0;
        end
        MEASURE: begin
          win_cnt <= win_cnt + 1'b1;
          if (!stop && win_last) result_timeout <= 1'b1;
        end
        WAIT_FLAG: dly_cnt <= '0;
        SETTLE: begin
          dly_cnt <= dly_cnt + 1'b1;
          phase   <= 1'b0;
          att_cnt <= '0;
        end
        SAMPLE: begin
          phase <= ~phase;
          if (!phase) s0 <= osc_count;
          else if (samp_match) begin
            result_data     <= osc_count;
            result_unstable <= 1'b0;
          end else if (att_last) begin
            result_data     <= osc_count;
            result_unstable <= 1'b1;
          end else att_cnt <= att_cnt + 1'b1;
        end
        OUTPUT: dly_cnt <= '0;
        CLEAR:  dly_cnt <= dly_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start) state_d = MEASURE;
      MEASURE:   if (stop || win_last) state_d = WAIT_FLAG;
      WAIT_FLAG: if (has_sync[SYNC_STAGES-1]) state_d = SETTLE;
      SETTLE:    if (settle_last) state_d = SAMPLE;
      SAMPLE:    if (phase && (samp_match || att_last)) state_d = OUTPUT;
      OUTPUT:    if (result_ready) state_d = CLEAR;
      CLEAR:     if (clear_last) state_d = IDLE;
      default:   state_d = CLEAR;
    endcase
  end

  // Registered outputs decode the next state, so enable/reset are mutually exclusive.
  always_comb begin
    en_d  = (state_d == MEASURE);
    rst_d = (state_d == CLEAR);
    vld_d = (state_d == OUTPUT);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Directed bench for tdc_capture_ctrl; oscillator modelled by driving count/flag by hand.
module tb_tdc_capture_ctrl;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset, start, stop, result_ready, osc_has_value;
  logic [BW-1:0] osc_count;
  logic          osc_enable, osc_reset, result_timeout, result_unstable, result_valid, busy;
  logic [BW-1:0] result_data;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_capture_ctrl #(
    .BIT_COUNT(BW), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .MAX_SAMPLES(4),
    .CLEAR_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .osc_enable(osc_enable), .osc_reset(osc_reset),
    .osc_count(osc_count), .osc_has_value(osc_has_value),
    .result_data(result_data), .result_timeout(result_timeout),
    .result_unstable(result_unstable), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", result_valid, 1'b1);
  endtask

  // Check the presented result, handshake it, and confirm the clear sequence.
  task automatic take_result(input string tag, input logic [31:0] d, input logic to, input logic un);
    chk({tag, "_data"}, result_data, d);
    chk({tag, "_timeout"}, result_timeout, to);
    chk({tag, "_unstable"}, result_unstable, un);
    result_ready = 1'b1; @(negedge clk); result_ready = 1'b0;
    osc_has_value = 1'b0; osc_count = '0;
    chk({tag, "_valid_drop"}, result_valid, 1'b0);
    chk({tag, "_clr1"}, osc_reset, 1'b1);
    @(negedge clk);
    chk({tag, "_clr2"}, osc_reset, 1'b1);
    @(negedge clk);
    chk({tag, "_clr_done"}, osc_reset, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; stop = 1'b0; result_ready = 1'b0;
    osc_has_value = 1'b0; osc_count = '0;

    // 1: reset and clear sequence
    tick(3);
    chk("rst_osc_reset", osc_reset, 1'b1);
    chk("rst_enable", osc_enable, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_data", result_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_clr1", osc_reset, 1'b1);
    @(negedge clk);
    chk("rel_clr_done", osc_reset, 1'b0);
    chk("rel_busy", busy, 1'b0);
    chk("rel_enable", osc_enable, 1'b0);
    chk("rel_valid", result_valid, 1'b0);

    // 2: normal window, stalled consumer
    osc_count = 32'h1234;
    pulse_start();
    chk("t2_en_on", osc_enable, 1'b1);
    chk("t2_busy", busy, 1'b1);
    tick(9);
    pulse_stop();
    chk("t2_en_off", osc_enable, 1'b0);
    tick(2);
    osc_has_value = 1'b1;
    wait_valid(n);
    chk("t2_latency", n, 9);
    tick(3);
    chk("t2_stall_valid", result_valid, 1'b1);
    chk("t2_stall_data", result_data, 32'h1234);
    take_result("t2", 32'h1234, 1'b0, 1'b0);

    // 3: timeout closes the window after exactly 16 cycles
    osc_count = 32'hABCD;
    pulse_start();
    n = 0;
    while (osc_enable && n < 100) begin n++; @(negedge clk); end
    chk("t3_en_cycles", n, 16);
    osc_has_value = 1'b1;
    wait_valid(n);
    take_result("t3", 32'hABCD, 1'b1, 1'b0);

    // 4a: count ramps through the first samples then settles at 0x50
    pulse_start(); tick(2); pulse_stop();
    osc_count = 32'h46; osc_has_value = 1'b1;
    n = 0;
    while (!result_valid && n < 80) begin
      @(negedge clk); n++;
      if (osc_count < 32'h50) osc_count = osc_count + 1;
    end
    chk("t4a_latency", n, 13);
    take_result("t4a", 32'h50, 1'b0, 1'b0);

    // 4b: count never stable -> unstable after 4 attempts
    pulse_start(); tick(2); pulse_stop();
    osc_count = 32'h100; osc_has_value = 1'b1;
    n = 0;
    while (!result_valid && n < 80) begin
      @(negedge clk); n++;
      if (!result_valid) osc_count = osc_count + 1;
    end
    chk("t4b_latency", n, 15);
    take_result("t4b", 32'h10E, 1'b0, 1'b1);

    // 5: start inside the window does not restart the timer
    osc_count = 32'h55;
    pulse_start();
    n = 0;
    while (osc_enable && n < 100) begin
      n++;
      start = (n == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk("t5_restart_ignored", n, 16);
    osc_has_value = 1'b1;
    wait_valid(n);
    take_result("t5a", 32'h55, 1'b1, 1'b0);
    pulse_stop();
    chk("t5_stop_idle_busy", busy, 1'b0);
    chk("t5_stop_idle_en", osc_enable, 1'b0);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("t5_both_en", osc_enable, 1'b1);
    tick(5);
    chk("t5_both_open", osc_enable, 1'b1);
    osc_count = 32'h66;
    pulse_stop();
    chk("t5_both_close", osc_enable, 1'b0);
    osc_has_value = 1'b1;
    wait_valid(n);
    take_result("t5b", 32'h66, 1'b0, 1'b0);

    // 6: reset during MEASURE and during OUTPUT
    pulse_start(); tick(3);
    reset = 1'b0; @(negedge clk);
    chk("t6m_en", osc_enable, 1'b0);
    chk("t6m_valid", result_valid, 1'b0);
    chk("t6m_osc_reset", osc_reset, 1'b1);
    reset = 1'b1; tick(2);
    chk("t6m_idle", busy, 1'b0);
    osc_count = 32'h99;
    pulse_start(); tick(2); pulse_stop();
    osc_has_value = 1'b1;
    wait_valid(n);
    reset = 1'b0; @(negedge clk);
    osc_has_value = 1'b0;
    chk("t6o_valid", result_valid, 1'b0);
    chk("t6o_en", osc_enable, 1'b0);
    chk("t6o_data", result_data, 32'h0);
    reset = 1'b1; @(negedge clk);
    chk("t6o_clr", osc_reset, 1'b1);
    @(negedge clk);
    chk("t6o_idle", busy, 1'b0);
    osc_count = 32'h7777;
    pulse_start(); tick(4); pulse_stop();
    tick(1);
    osc_has_value = 1'b1;
    wait_valid(n);
    take_result("t6", 32'h7777, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
